// File: rtl/serial_add_sub_if.sv
// serial_add_sub operand/result bundle.
// master issues start with operands; slave returns the result.
interface serial_add_sub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             overflow;

   modport master (
      output start, mode, a, b,
      input  busy, done, result, cout, overflow
   );

   modport slave (
      input  start, mode, a, b,
      output busy, done, result, cout, overflow
   );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement add/subtract, LSB first.
// One full-adder cell with a registered carry; WIDTH cycles per op.
module serial_add_sub #(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst,
   serial_add_sub_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_n;

   logic [WIDTH-1:0] a_sr, a_sr_n;
   logic [WIDTH-1:0] b_sr, b_sr_n;
   logic [WIDTH-1:0] r_sr, r_sr_n;
   logic [WIDTH-1:0] res_q, res_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             mode_q, mode_n;
   logic             carry, carry_n;
   logic             cout_q, cout_n;
   logic             ovf_q, ovf_n;
   logic             busy_q, busy_n;
   logic             done_q, done_n;

   logic             bit_a, bit_b;
   logic             s, c;
   logic             last;
   logic             load;

   // single full-adder cell; subtract inverts b and seeds carry with 1
   always_comb begin
      bit_a = a_sr[0];
      bit_b = b_sr[0] ^ mode_q;
      s     = bit_a ^ bit_b ^ carry;
      c     = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
      last  = (cnt == CW'(WIDTH - 1));
      load  = bus.start && ((state == IDLE) || (state == DONE));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      a_sr_n  = a_sr;
      b_sr_n  = b_sr;
      r_sr_n  = r_sr;
      res_n   = res_q;
      cnt_n   = cnt;
      mode_n  = mode_q;
      carry_n = carry;
      cout_n  = cout_q;
      ovf_n   = ovf_q;
      done_n  = 1'b0;

      unique case (state)
         IDLE, DONE: begin
            state_n = IDLE;
            if (load) begin
               state_n = SHIFT;
               a_sr_n  = bus.a;
               b_sr_n  = bus.b;
               mode_n  = bus.mode;
               carry_n = bus.mode;
               cnt_n   = '0;
            end
         end
         SHIFT: begin
            a_sr_n  = a_sr >> 1;
            b_sr_n  = b_sr >> 1;
            r_sr_n  = (r_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
            carry_n = c;
            cnt_n   = cnt + CW'(1);
            if (last) begin
               state_n = DONE;
               res_n   = r_sr_n;
               cout_n  = c;
               // carry still holds the carry into the MSB here
               ovf_n   = carry ^ c;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n == SHIFT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         r_sr   <= '0;
         res_q  <= '0;
         cnt    <= '0;
         mode_q <= 1'b0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         a_sr   <= a_sr_n;
         b_sr   <= b_sr_n;
         r_sr   <= r_sr_n;
         res_q  <= res_n;
         cnt    <= cnt_n;
         mode_q <= mode_n;
         carry  <= carry_n;
         cout_q <= cout_n;
         ovf_q  <= ovf_n;
         busy_q <= busy_n;
         done_q <= done_n;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.result   = res_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: WIDTH=8 vectors
// plus an exhaustive WIDTH=3 sweep against a signed model.
module tb_serial_add_sub;

   logic clk;
   logic rst;

   int n_assert;
   int n_fail;

   serial_add_sub_if #(.WIDTH(8)) bus8 ();
   serial_add_sub_if #(.WIDTH(3)) bus3 ();

   serial_add_sub #(.WIDTH(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.slave)
   );

   serial_add_sub #(.WIDTH(3)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // returns edges after E0 until done, and busy cycles seen
   task automatic wait_done8(output int cyc, output int bcyc);
      cyc  = 0;
      bcyc = 0;
      while (!bus8.done && cyc < 40) begin
         if (bus8.busy) bcyc++;
         tick();
         cyc++;
      end
   endtask

   task automatic op8(input string tag,
                      input logic m,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [7:0] er,
                      input logic ec,
                      input logic eo);
      int cyc, bcyc;
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.mode  = m;
      bus8.a     = a;
      bus8.b     = b;
      tick();
      bus8.start = 1'b0;
      wait_done8(cyc, bcyc);
      chk({tag, "_lat"},  cyc, 8);
      chk({tag, "_busy"}, bcyc, 8);
      chk({tag, "_done"}, {31'd0, bus8.done}, 1);
      chk({tag, "_res"},  {24'd0, bus8.result}, {24'd0, er});
      chk({tag, "_cout"}, {31'd0, bus8.cout}, {31'd0, ec});
      chk({tag, "_ovf"},  {31'd0, bus8.overflow}, {31'd0, eo});
      tick();
      chk({tag, "_pulse"}, {31'd0, bus8.done}, 0);
   endtask

   task automatic op3(input logic m,
                      input logic [2:0] a,
                      input logic [2:0] b);
      int cyc;
      int sa, sb, sr, uu;
      logic [2:0] er;
      logic ec, eo;
      sa = (a >= 3'd4) ? int'(a) - 8 : int'(a);
      sb = (b >= 3'd4) ? int'(b) - 8 : int'(b);
      sr = m ? sa - sb : sa + sb;
      uu = m ? int'(a) + (7 - int'(b)) + 1 : int'(a) + int'(b);
      er = 3'(uu);
      ec = (uu >= 8);
      eo = (sr > 3) || (sr < -4);
      @(negedge clk);
      bus3.start = 1'b1;
      bus3.mode  = m;
      bus3.a     = a;
      bus3.b     = b;
      tick();
      bus3.start = 1'b0;
      cyc = 0;
      while (!bus3.done && cyc < 20) begin
         tick();
         cyc++;
      end
      chk($sformatf("w3_m%0d_a%0d_b%0d", m, a, b),
          {26'd0, cyc[1:0], bus3.result, bus3.cout, bus3.overflow},
          {26'd0, 2'd3, er, ec, eo});
   endtask

   initial begin
      int cyc, bcyc, seen;
      n_assert    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      bus8.start  = 1'b0;
      bus8.mode   = 1'b0;
      bus8.a      = '0;
      bus8.b      = '0;
      bus3.start  = 1'b0;
      bus3.mode   = 1'b0;
      bus3.a      = '0;
      bus3.b      = '0;
      #1;
      chk("rst_outs",
          {20'd0, bus8.busy, bus8.done, bus8.result, bus8.cout, bus8.overflow},
          0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      op8("add5p3",  1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
      op8("addFFp1", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      op8("add7Fp1", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
      op8("sub3m5",  1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0);
      op8("sub80m1", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

      // restart attempt mid-SHIFT must be ignored
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.mode  = 1'b0;
      bus8.a     = 8'h05;
      bus8.b     = 8'h03;
      tick();
      bus8.start = 1'b0;
      tick();
      tick();
      bus8.start = 1'b1;
      bus8.mode  = 1'b1;
      bus8.a     = 8'h10;
      bus8.b     = 8'h20;
      tick();
      bus8.start = 1'b0;
      chk("mid_res_held", {24'd0, bus8.result}, 32'h7F);
      wait_done8(cyc, bcyc);
      chk("mid_lat", cyc, 5);
      chk("mid_res", {24'd0, bus8.result, bus8.cout, bus8.overflow},
          {24'd0, 8'h08, 1'b0, 1'b0});
      tick();
      chk("mid_idle", {30'd0, bus8.busy, bus8.done}, 0);

      // reset on the 4th SHIFT cycle
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.mode  = 1'b0;
      bus8.a     = 8'hFF;
      bus8.b     = 8'h01;
      tick();
      bus8.start = 1'b0;
      tick();
      tick();
      tick();
      chk("rst4_busy_pre", {31'd0, bus8.busy}, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst4_outs",
          {20'd0, bus8.busy, bus8.done, bus8.result, bus8.cout, bus8.overflow},
          0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus8.done || bus8.busy) seen++;
      end
      chk("rst4_no_done", seen, 0);
      op8("post_rst", 1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);

      // back-to-back: new start accepted in DONE
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.mode  = 1'b0;
      bus8.a     = 8'h12;
      bus8.b     = 8'h34;
      tick();
      bus8.start = 1'b0;
      wait_done8(cyc, bcyc);
      chk("b2b_first", {23'd0, bus8.done, bus8.result}, {23'd0, 1'b1, 8'h46});
      bus8.start = 1'b1;
      bus8.mode  = 1'b1;
      bus8.a     = 8'h10;
      bus8.b     = 8'h20;
      tick();
      bus8.start = 1'b0;
      chk("b2b_flags", {30'd0, bus8.busy, bus8.done}, 32'd2);
      wait_done8(cyc, bcyc);
      chk("b2b_lat", cyc + 1, 9);
      chk("b2b_second",
          {22'd0, bus8.done, bus8.result, bus8.cout, bus8.overflow},
          {22'd0, 1'b1, 8'hF0, 1'b0, 1'b0});
      tick();

      for (int m = 0; m < 2; m++)
         for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
               op3(m[0], a[2:0], b[2:0]);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial two's-complement adder/subtractor built around a single full-adder cell and a registered carry.
- Consumes parallel operands and processes one bit per clock, LSB first.
- Returns a parallel result with carry, signed overflow, and a done pulse.
- Serves as the sequential, area-minimal counterpart to the combinational full-adder path. It is the block a control sequencer drives, rather than a one-shot combinational evaluation.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse when result/cout/overflow become valid.
- result  output  WIDTH  sum/difference; held until the next accepted start completes.
- cout  output  1  final carry out. For subtract, 1 = no borrow (a >= b unsigned).
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; busy, done, result, cout, overflow and all internal shift/carry/count registers = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start = 1 at a clock edge: load shift regs with a and b, latch mode, set carry register = mode, count = 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each edge:
  - bit_a = A_sr[0]; bit_b = B_sr[0] XOR mode.
  - s = bit_a ^ bit_b ^ carry; c = majority(bit_a, bit_b, carry).
  - Shift s into the result shift register from the MSB side; shift A_sr and B_sr right; carry <= c; count <= count + 1.
  - On the edge processing bit WIDTH-1:
    - record the carry-in to that bit for the overflow calculation;
    - go to DONE;
    - transfer the assembled value to result, c to cout, and (carry-in XOR c) to overflow;
    - set done = 1.
- busy = 1 exactly for the WIDTH cycles spent in SHIFT. busy is registered, not combinational from start.
- Latency: start sampled at edge E0 leads to busy high E0..E(WIDTH). done, result, cout and overflow are valid after edge E(WIDTH) for exactly one cycle of done.
- DONE, lasts one cycle:
  - If start = 1, accept the new operands exactly as from IDLE (back-to-back; done drops, busy rises next cycle).
  - Otherwise go to IDLE and done drops.
- start is ignored while in SHIFT; operand/mode changes during SHIFT have no effect.
- result/cout/overflow change only on the DONE-entry edge or on reset. They are stable between operations.
- Count register width is clog2(WIDTH)+1. No wrap-around beyond WIDTH-1 is possible.
- Reset asserted mid-SHIFT aborts the operation; no done pulse. The next start after reset release behaves as from power-up.

Test Plan:
- Reset then add 0x05+0x03 (WIDTH=8) -> busy high 8 cycles, done pulse 8 cycles after the start edge, result 0x08, cout 0, overflow 0.
- Add 0xFF+0x01 -> result 0x00, cout 1, overflow 0.
- Add 0x7F+0x01 -> result 0x80, cout 0, overflow 1.
- Subtract 0x03-0x05 -> result 0xFE, cout 0, overflow 0.
- Subtract 0x80-0x01 -> result 0x7F, cout 1, overflow 1.
- start re-pulsed with new operands mid-SHIFT -> ignored, first result unchanged.
- Reset asserted on the 4th SHIFT cycle -> all outputs 0 immediately, no done.
- Back-to-back start in DONE -> second op completes WIDTH+1 cycles later.
- WIDTH=3 exhaustive sweep, all a, b, mode (128 cases) -> result/cout/overflow match a reference model computed in the bench.
